// File: rtl/gat_host_bram_loader.sv
// Host-side BRAM loader for the GAT accelerator: streams input words into the
// H-data, node-info and weight BRAMs, waits for gat_ready, then reads the
// new-feature BRAM back out onto an output stream.
module gat_host_bram_loader #(
    parameter int unsigned TOP_WIDTH          = 32,
    parameter int unsigned H_DATA_ADDR_W      = 18,
    parameter int unsigned NODE_INFO_ADDR_W   = 14,
    parameter int unsigned WEIGHT_ADDR_W      = 15,
    parameter int unsigned NEW_FEATURE_ADDR_W = 16,
    parameter int unsigned RD_LAT             = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [H_DATA_ADDR_W:0]        h_data_len,
    input  logic [NODE_INFO_ADDR_W:0]     node_info_len,
    input  logic [WEIGHT_ADDR_W:0]        wgt_len,
    input  logic [NEW_FEATURE_ADDR_W:0]   feat_len,
    input  logic [TOP_WIDTH-1:0]          s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [TOP_WIDTH-1:0]          h_data_bram_din,
    output logic                          h_data_bram_ena,
    output logic                          h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,
    output logic [TOP_WIDTH-1:0]          h_node_info_bram_din,
    output logic                          h_node_info_bram_ena,
    output logic                          h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0]          wgt_bram_din,
    output logic                          wgt_bram_ena,
    output logic                          wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,
    output logic                          h_data_bram_load_done,
    output logic                          h_node_info_bram_load_done,
    output logic                          wgt_bram_load_done,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [TOP_WIDTH-1:0]          feat_bram_dout,
    output logic [TOP_WIDTH-1:0]          m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          busy,
    output logic                          done
);

    // idx must cover the widest length input; it never wraps within a run.
    localparam int unsigned MaxAB = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ?
                                    H_DATA_ADDR_W : NODE_INFO_ADDR_W;
    localparam int unsigned MaxCD = (WEIGHT_ADDR_W > NEW_FEATURE_ADDR_W) ?
                                    WEIGHT_ADDR_W : NEW_FEATURE_ADDR_W;
    localparam int unsigned IdxW  = ((MaxAB > MaxCD) ? MaxAB : MaxCD) + 1;
    localparam int unsigned LatW  = $clog2(RD_LAT + 2);

    typedef enum logic [3:0] {
        StIdle,
        StLoadH,
        StLoadNi,
        StLoadW,
        StWaitRdy,
        StRdIssue,
        StRdWait,
        StRdOut,
        StFin
    } state_e;

    state_e                        state_q, state_d;
    logic [IdxW-1:0]               idx_q, idx_d;
    logic [IdxW-1:0]               idx_inc;
    logic [IdxW-1:0]               load_len;
    logic [IdxW-1:0]               f_len_ext;
    logic [H_DATA_ADDR_W:0]        h_len_q, h_len_d;
    logic [NODE_INFO_ADDR_W:0]     ni_len_q, ni_len_d;
    logic [WEIGHT_ADDR_W:0]        w_len_q, w_len_d;
    logic [NEW_FEATURE_ADDR_W:0]   f_len_q, f_len_d;
    logic                          h_done_q, h_done_d;
    logic                          ni_done_q, ni_done_d;
    logic                          w_done_q, w_done_d;
    logic [TOP_WIDTH-1:0]          wr_din_q, wr_din_d;
    logic                          h_ena_q, h_ena_d;
    logic                          ni_ena_q, ni_ena_d;
    logic                          w_ena_q, w_ena_d;
    logic [H_DATA_ADDR_W+1:0]      h_addr_q, h_addr_d;
    logic [NODE_INFO_ADDR_W+1:0]   ni_addr_q, ni_addr_d;
    logic [WEIGHT_ADDR_W+1:0]      w_addr_q, w_addr_d;
    logic [NEW_FEATURE_ADDR_W+1:0] rd_addr_q, rd_addr_d;
    logic [LatW-1:0]               lat_cnt_q, lat_cnt_d;
    logic [TOP_WIDTH-1:0]          m_tdata_q, m_tdata_d;
    logic                          m_tvalid_q, m_tvalid_d;
    logic                          m_tlast_q, m_tlast_d;

    assign idx_inc   = idx_q + IdxW'(1);
    assign f_len_ext = IdxW'(f_len_q);

    // Next-state, datapath updates and the stream-side handshake.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        h_len_d    = h_len_q;
        ni_len_d   = ni_len_q;
        w_len_d    = w_len_q;
        f_len_d    = f_len_q;
        h_done_d   = h_done_q;
        ni_done_d  = ni_done_q;
        w_done_d   = w_done_q;
        wr_din_d   = wr_din_q;
        h_ena_d    = 1'b0;
        ni_ena_d   = 1'b0;
        w_ena_d    = 1'b0;
        h_addr_d   = h_addr_q;
        ni_addr_d  = ni_addr_q;
        w_addr_d   = w_addr_q;
        rd_addr_d  = rd_addr_q;
        lat_cnt_d  = lat_cnt_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        s_tready   = 1'b0;
        load_len   = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    h_len_d   = h_data_len;
                    ni_len_d  = node_info_len;
                    w_len_d   = wgt_len;
                    f_len_d   = feat_len;
                    h_done_d  = 1'b0;
                    ni_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    idx_d     = '0;
                    state_d   = StLoadH;
                end
            end

            StLoadH: begin
                load_len = IdxW'(h_len_q);
                // No beat is taken for an empty region, so nothing is lost on skip.
                s_tready = (load_len != '0);
                if (load_len == '0) begin
                    h_done_d = 1'b1;
                    state_d  = StLoadNi;
                end else if (s_tvalid) begin
                    h_ena_d  = 1'b1;
                    wr_din_d = s_tdata;
                    h_addr_d = {idx_q[H_DATA_ADDR_W-1:0], 2'b00};
                    idx_d    = idx_inc;
                    if (idx_inc == load_len) begin
                        h_done_d = 1'b1;
                        idx_d    = '0;
                        state_d  = StLoadNi;
                    end
                end
            end

            StLoadNi: begin
                load_len = IdxW'(ni_len_q);
                s_tready = (load_len != '0);
                if (load_len == '0) begin
                    ni_done_d = 1'b1;
                    state_d   = StLoadW;
                end else if (s_tvalid) begin
                    ni_ena_d  = 1'b1;
                    wr_din_d  = s_tdata;
                    ni_addr_d = {idx_q[NODE_INFO_ADDR_W-1:0], 2'b00};
                    idx_d     = idx_inc;
                    if (idx_inc == load_len) begin
                        ni_done_d = 1'b1;
                        idx_d     = '0;
                        state_d   = StLoadW;
                    end
                end
            end

            StLoadW: begin
                load_len = IdxW'(w_len_q);
                s_tready = (load_len != '0);
                if (load_len == '0) begin
                    w_done_d = 1'b1;
                    state_d  = StWaitRdy;
                end else if (s_tvalid) begin
                    w_ena_d  = 1'b1;
                    wr_din_d = s_tdata;
                    w_addr_d = {idx_q[WEIGHT_ADDR_W-1:0], 2'b00};
                    idx_d    = idx_inc;
                    if (idx_inc == load_len) begin
                        w_done_d = 1'b1;
                        idx_d    = '0;
                        state_d  = StWaitRdy;
                    end
                end
            end

            StWaitRdy: begin
                if (gat_ready) begin
                    state_d = (f_len_ext == '0) ? StFin : StRdIssue;
                end
            end

            StRdIssue: begin
                rd_addr_d = {idx_q[NEW_FEATURE_ADDR_W-1:0], 2'b00};
                lat_cnt_d = '0;
                state_d   = StRdWait;
            end

            // Waits RD_LAT cycles past the address update, then samples dout.
            StRdWait: begin
                if (lat_cnt_q == LatW'(RD_LAT)) begin
                    m_tdata_d  = feat_bram_dout;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (idx_inc == f_len_ext);
                    state_d    = StRdOut;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end

            StRdOut: begin
                if (m_tready) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                    idx_d      = idx_inc;
                    state_d    = (idx_inc == f_len_ext) ? StFin : StRdIssue;
                end
            end

            StFin: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset also drops any write strobe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            h_len_q    <= '0;
            ni_len_q   <= '0;
            w_len_q    <= '0;
            f_len_q    <= '0;
            h_done_q   <= 1'b0;
            ni_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_din_q   <= '0;
            h_ena_q    <= 1'b0;
            ni_ena_q   <= 1'b0;
            w_ena_q    <= 1'b0;
            h_addr_q   <= '0;
            ni_addr_q  <= '0;
            w_addr_q   <= '0;
            rd_addr_q  <= '0;
            lat_cnt_q  <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            h_len_q    <= h_len_d;
            ni_len_q   <= ni_len_d;
            w_len_q    <= w_len_d;
            f_len_q    <= f_len_d;
            h_done_q   <= h_done_d;
            ni_done_q  <= ni_done_d;
            w_done_q   <= w_done_d;
            wr_din_q   <= wr_din_d;
            h_ena_q    <= h_ena_d;
            ni_ena_q   <= ni_ena_d;
            w_ena_q    <= w_ena_d;
            h_addr_q   <= h_addr_d;
            ni_addr_q  <= ni_addr_d;
            w_addr_q   <= w_addr_d;
            rd_addr_q  <= rd_addr_d;
            lat_cnt_q  <= lat_cnt_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    // The write data register is shared; only the enabled port consumes it.
    assign h_data_bram_din            = wr_din_q;
    assign h_data_bram_ena            = h_ena_q;
    assign h_data_bram_wea            = h_ena_q;
    assign h_data_bram_addra          = h_addr_q;
    assign h_node_info_bram_din       = wr_din_q;
    assign h_node_info_bram_ena       = ni_ena_q;
    assign h_node_info_bram_wea       = ni_ena_q;
    assign h_node_info_bram_addra     = ni_addr_q;
    assign wgt_bram_din               = wr_din_q;
    assign wgt_bram_ena               = w_ena_q;
    assign wgt_bram_wea               = w_ena_q;
    assign wgt_bram_addra             = w_addr_q;
    assign h_data_bram_load_done      = h_done_q;
    assign h_node_info_bram_load_done = ni_done_q;
    assign wgt_bram_load_done         = w_done_q;
    assign feat_bram_addrb            = rd_addr_q;
    assign m_tdata                    = m_tdata_q;
    assign m_tvalid                   = m_tvalid_q;
    assign m_tlast                    = m_tlast_q;
    assign busy                       = (state_q != StIdle) && (state_q != StFin);
    assign done                       = (state_q == StFin);

endmodule

// File: doc/gat_host_bram_loader.md
Name: gat_host_bram_loader

Overview:
- Host-side counterpart of the GAT accelerator's BRAM/register-bank interface.
- Accepts a 32-bit input word stream and writes it sequentially into the H-data, H-node-info and weight BRAMs using byte addresses (word index << 2), raising each region's load_done flag as it completes.
- After the accelerator reports gat_ready, reads the new-feature BRAM through its byte-addressed read port and emits the words on an output stream.
- Replaces software PIO loading for bring-up and throughput tests.

Parameters:
TOP_WIDTH, 32, data/stream word width
H_DATA_ADDR_W, 18, H-data word-address width (byte address = H_DATA_ADDR_W+2 bits)
NODE_INFO_ADDR_W, 14, node-info word-address width
WEIGHT_ADDR_W, 15, weight word-address width
NEW_FEATURE_ADDR_W, 16, feature word-address width
RD_LAT, 2, cycles from feat_bram_addrb register update to valid feat_bram_dout

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
h_data_len  in  H_DATA_ADDR_W+1  H-data words to load
node_info_len  in  NODE_INFO_ADDR_W+1  node-info words to load
wgt_len  in  WEIGHT_ADDR_W+1  weight words to load
feat_len  in  NEW_FEATURE_ADDR_W+1  feature words to read back
s_tdata  in  TOP_WIDTH  input word
s_tvalid  in  1  input word valid
s_tready  out  1  input word accepted when s_tvalid&s_tready
h_data_bram_din / _ena / _wea / _addra  out  TOP_WIDTH/1/1/H_DATA_ADDR_W+2  H-data write port
h_node_info_bram_din / _ena / _wea / _addra  out  TOP_WIDTH/1/1/NODE_INFO_ADDR_W+2  node-info write port
wgt_bram_din / _ena / _wea / _addra  out  TOP_WIDTH/1/1/WEIGHT_ADDR_W+2  weight write port
h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done  out  1 each  region loaded (level)
gat_ready  in  1  accelerator finished
feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  feature byte read address
feat_bram_dout  in  TOP_WIDTH  feature read data
m_tdata  out  TOP_WIDTH  output word
m_tvalid  out  1  output word valid
m_tready  in  1  downstream accept
m_tlast  out  1  marks last feature word
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end

Behaviour:
- Clock/reset: single clock clk; reset rst is asynchronous and active-high. All outputs reset to 0 and FSM resets to IDLE. Reset mid-run aborts immediately with no further BRAM writes; a mid-write ena/wea deasserts asynchronously.
- States: IDLE -> LOAD_H -> LOAD_NI -> LOAD_W -> WAIT_RDY -> RD_ISSUE -> RD_WAIT -> RD_OUT -> (RD_ISSUE | FIN) -> IDLE.
- IDLE: start latches the four lengths, clears all three load_done flags and the word counter idx, and sets busy. start is ignored when busy=1.
- LOAD_* handshake: s_tready=1 in the LOAD_* states only.
- LOAD_* write: each accepted beat registers din=s_tdata, addra={idx,2'b00}, ena=wea=1 for exactly one cycle (the cycle after the handshake) on that region's port only. idx then increments; the other ports hold ena=wea=0.
- LOAD_* full rate: one write per cycle when s_tvalid is held high.
- LOAD_* completion: when idx reaches the region length, the FSM advances, idx clears and the region's load_done rises in the same cycle as its last write and stays high until the next start.
- Zero-length region: its state is skipped in one cycle, load_done sets, no writes occur.
- WAIT_RDY: waits for gat_ready=1 (sampled only here).
- feat_len=0: go to FIN with no stream output.
- RD_ISSUE: registers feat_bram_addrb={idx,2'b00}.
- RD_WAIT: counts RD_LAT cycles, then captures feat_bram_dout into m_tdata.
- RD_OUT: m_tvalid=1; m_tlast=1 when idx==feat_len-1. m_tdata, m_tvalid and m_tlast are stable until m_tready. On the handshake, idx increments; the FSM goes to RD_ISSUE, or to FIN after the last word.
- FIN: done=1 for one cycle, busy=0. The load_done flags remain set.
- Counter wrap: none. Lengths exceeding the address range are unsupported; idx width is len width and never wraps within a run.

Test Plan:
- Reset mid-LOAD_H after 3 writes -> all outputs 0 next cycle; a new start reloads from addra=0.
- start with h_data_len=4, node_info_len=2, wgt_len=3, feat_len=0, stream 9 words back-to-back -> H writes at addra 0,4,8,12; NI at 0,4; W at 0,4,8. Each load_done rises on its last write. done pulses once gat_ready=1, with no m_tvalid.
- Input stalls (s_tvalid toggling 1,0,0,1) -> no write in stall cycles; addresses contiguous; data order preserved.
- node_info_len=0 -> LOAD_NI skipped; h_node_info_bram_ena never asserted; its load_done set.
- feat_len=3, BRAM model returning 0xA0+word_index, m_tready low 5 cycles on word 1 -> m_tdata 0xA0, 0xA1, 0xA2 in order, held during stall. feat_bram_addrb 0,4,8; m_tlast only on 0xA2.
- start pulsed while busy -> ignored; lengths unchanged; single done pulse.
